bus_arbiter_mux: RTL and testbench
==================================

BUS_ARBITER_MUX -- requirements
Module: bus_arbiter_mux

Interface
REQ-001 Parameter WIDTH, default 32: bit width of every source word and of the bus.
REQ-002 Parameter NSRC, default 24: number of bus sources, legal range 2..32.
REQ-003 Parameter IDXW, default 5: width of the grant index; SHALL satisfy 2**IDXW >= NSRC.
REQ-004 Parameter MAX_HOLD, default 16: maximum locked-grant length in cycles; used only when BUS_ARB_TIMEOUT_EN is defined.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 clr  in  1  reset; synchronous, active-high.
REQ-007 src_data  in  NSRC*WIDTH  flattened source words; source i occupies bits [i*WIDTH +: WIDTH].
REQ-008 req  in  NSRC  per-source bus request, level-sensitive.
REQ-009 lock  in  1  asks to keep the current grant across cycles (burst).
REQ-010 bus_out  out  WIDTH  registered bus value.
REQ-011 bus_valid  out  1  bus_out carries the granted source's data.
REQ-012 gnt  out  NSRC  one-hot grant, registered.
REQ-013 gnt_idx  out  IDXW  encoded index of the granted source.
REQ-014 timeout  out  1  one-cycle pulse when a lock is forcibly released; tied to 0 when the feature is compiled out.

Function
REQ-015 The FSM SHALL have two states: IDLE (no grant) and GRANT (exactly one gnt bit set).
REQ-016 Arbitration SHALL be round-robin: choose the first asserted req at or above pointer ptr, wrapping from NSRC-1 to 0.
REQ-017 ptr SHALL update to (granted index + 1) mod NSRC on every new grant.
REQ-018 IDLE with req == 0: remain in IDLE; bus_out = 0, bus_valid = 0, gnt = 0.
REQ-019 IDLE with any req set at edge k: after edge k, state = GRANT, gnt and gnt_idx show the winner, bus_out = that source's word as sampled at edge k, bus_valid = 1.
REQ-020 While in GRANT, bus_out SHALL reload src_data of the granted index on every edge (one-cycle latency).
REQ-021 GRANT with lock = 1 and req[gnt_idx] = 1: hold the grant; other requests are ignored.
REQ-022 GRANT with lock = 0: re-arbitrate on every edge from ptr; a sole requester SHALL be re-granted back-to-back with no bubble.
REQ-023 GRANT with req[gnt_idx] = 0 and no other request: go to IDLE; bus_out = 0 and bus_valid = 0 on the next cycle.
REQ-024 GRANT with req[gnt_idx] = 0 and other requests pending: grant the next requester directly, with no idle cycle.
REQ-025 A request from an index >= NSRC SHALL never be granted; gnt SHALL never have more than one bit set.

Reset
REQ-026 While clr = 1 at a rising edge: state = IDLE, ptr = 0, bus_out = 0, bus_valid = 0, gnt = 0, gnt_idx = 0, timeout = 0, hold counter = 0.
REQ-027 Reset SHALL take priority over every other input, including during a locked grant; the grant is dropped with no timeout pulse.

Configuration
REQ-028 Macro BUS_ARB_TIMEOUT_EN defined: a hold counter counts consecutive cycles a grant is held under lock.
REQ-029 When the counter reaches MAX_HOLD, the next edge SHALL force re-arbitration with the current holder excluded, and SHALL pulse timeout for one cycle.
REQ-030 The counter SHALL clear whenever the grant changes or lock = 0.
REQ-031 Macro undefined: no counter is built, a lock holds indefinitely, and timeout is constant 0.

Verification
REQ-032 Reset scenario: clr = 1 with req = all ones -> after the edge, all outputs are 0; release clr -> the next edge grants index 0.
REQ-033 Round-robin scenario: req bits 3, 7 and 20 held, lock = 0 -> gnt_idx sequence 3, 7, 20, 3, ...; bus_out equals src 3's word one cycle after the grant.
REQ-034 Lock scenario: index 5 granted, lock = 1, req[5] and req[9] held for 10 cycles -> gnt_idx stays 5; lock = 0 -> the next edge grants 9.
REQ-035 Release scenario: sole requester 12 drops req -> one cycle later bus_valid = 0 and bus_out = 0; req[12] reasserted -> regranted after one edge.
REQ-036 Timeout scenario (BUS_ARB_TIMEOUT_EN, MAX_HOLD = 4): index 2 locked with req[4] pending -> timeout pulses once; gnt_idx = 4 on the cycle after the 4th held cycle.
REQ-037 Mid-lock reset scenario: clr asserted mid-lock -> IDLE, timeout = 0, ptr = 0.

Source files
------------

// File: rtl/bus_arbiter_mux_if.sv
// Bus bundle for bus_arbiter_mux: source words, requests, lock, and the arbitrated bus outputs.
interface bus_arbiter_mux_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NSRC  = 24,
    parameter int unsigned IDXW  = 5
);
    logic [NSRC*WIDTH-1:0] src_data;
    logic [NSRC-1:0]       req;
    logic                  lock;
    logic [WIDTH-1:0]      bus_out;
    logic                  bus_valid;
    logic [NSRC-1:0]       gnt;
    logic [IDXW-1:0]       gnt_idx;
    logic                  timeout;

    modport master (
        output src_data, req, lock,
        input  bus_out, bus_valid, gnt, gnt_idx, timeout
    );

    modport slave (
        input  src_data, req, lock,
        output bus_out, bus_valid, gnt, gnt_idx, timeout
    );
endinterface

// File: rtl/bus_arbiter_mux.sv
// Round-robin bus arbiter with registered data mux and burst lock.
// Define BUS_ARB_TIMEOUT_EN to bound locked grants to MAX_HOLD held cycles.
module bus_arbiter_mux #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned NSRC     = 24,
    parameter int unsigned IDXW     = 5,
    parameter int unsigned MAX_HOLD = 16
) (
    input logic              clk,
    input logic              clr,
    bus_arbiter_mux_if.slave bus
);
    if (NSRC < 2 || NSRC > 32 || (1 << IDXW) < NSRC || MAX_HOLD < 1) begin : g_bad_params
        $error("bus_arbiter_mux: illegal parameter combination");
    end

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e           state_q, state_d;
    logic [IDXW-1:0]  ptr_q, ptr_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [NSRC-1:0]  gnt_q, gnt_d;
    logic [WIDTH-1:0] bus_q, bus_d;

    logic             hold;
    logic             force_rel;
    logic [NSRC-1:0]  cand;
    logic [NSRC-1:0]  mask;
    logic [NSRC-1:0]  hi;
    logic             found;
    logic [IDXW-1:0]  win;

    assign hold = (state_q == StGrant) && bus.lock && (|(bus.req & gnt_q));

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int unsigned CNTW = $clog2(MAX_HOLD + 1);

    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            timeout_q;

    assign force_rel = hold && (cnt_q == CNTW'(MAX_HOLD));

    // Counts edges on which a locked grant was kept; any other outcome restarts it.
    always_comb begin
        cnt_d = '0;
        if (hold && !force_rel) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= force_rel;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign force_rel   = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    // A forced release excludes the current holder from the next arbitration.
    assign cand = force_rel ? (bus.req & ~gnt_q) : bus.req;

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            mask[i] = (i >= int'(ptr_q));
        end
        hi    = cand & mask;
        found = |cand;
        win   = '0;
        // Lowest requester at or above ptr, else wrap to the lowest overall.
        for (int i = NSRC - 1; i >= 0; i--) begin
            if ((|hi) ? hi[i] : cand[i]) begin
                win = IDXW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        bus_d   = '0;
        if (hold && !force_rel) begin
            state_d = StGrant;
        end else if (found) begin
            state_d = StGrant;
            idx_d   = win;
            gnt_d   = NSRC'(1) << win;
            ptr_d   = (win == IDXW'(NSRC - 1)) ? '0 : win + 1'b1;
        end else begin
            state_d = StIdle;
            idx_d   = '0;
            gnt_d   = '0;
        end
        for (int i = 0; i < NSRC; i++) begin
            if (gnt_d[i]) begin
                bus_d = bus.src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            bus_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            bus_q   <= bus_d;
        end
    end

    assign bus.bus_out   = bus_q;
    assign bus.bus_valid = (state_q == StGrant);
    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Scoreboard bench for bus_arbiter_mux: directed scenarios plus random traffic against a
// round-robin reference model.
module tb_bus_arbiter_mux;
    localparam int unsigned WIDTH    = 32;
    localparam int unsigned NSRC     = 24;
    localparam int unsigned IDXW     = 5;
    localparam int unsigned MAX_HOLD = 4;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct {
        logic             valid;
        logic [NSRC-1:0]  gnt;
        logic [IDXW-1:0]  idx;
        logic [WIDTH-1:0] data;
        logic             tout;
    } exp_t;

    logic clk = 1'b0;
    logic clr;
    logic [WIDTH-1:0] data [NSRC];
    exp_t q[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int m_cur = -1;
    int m_ptr = 0;
    int m_cnt = 0;

    bus_arbiter_mux_if #(.WIDTH(WIDTH), .NSRC(NSRC), .IDXW(IDXW)) bus ();

    bus_arbiter_mux #(
        .WIDTH   (WIDTH),
        .NSRC    (NSRC),
        .IDXW    (IDXW),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, req);
        end
    endtask

    // Reference: walk indices from ptr with wrap, pick the first live request.
    task automatic model_edge(input logic c, input logic [NSRC-1:0] r, input logic l,
                              output exp_t e);
        bit held;
        bit tout;
        int excl;
        int winner;
        tout = 1'b0;
        if (c) begin
            m_cur = -1;
            m_ptr = 0;
            m_cnt = 0;
        end else begin
            held = (m_cur >= 0) && l && r[m_cur];
            if (held && !(TO_EN && m_cnt == int'(MAX_HOLD))) begin
                m_cnt++;
            end else begin
                excl   = held ? m_cur : -1;
                tout   = held;
                winner = -1;
                for (int k = 0; k < NSRC; k++) begin
                    int j;
                    j = (m_ptr + k) % NSRC;
                    if (winner < 0 && r[j] && j != excl) winner = j;
                end
                m_cur = winner;
                m_cnt = 0;
                if (winner >= 0) m_ptr = (winner + 1) % NSRC;
            end
        end
        e.valid = (m_cur >= 0);
        e.gnt   = '0;
        e.idx   = '0;
        e.data  = '0;
        if (m_cur >= 0) begin
            e.gnt[m_cur] = 1'b1;
            e.idx        = IDXW'(m_cur);
            e.data       = data[m_cur];
        end
        e.tout = tout;
    endtask

    task automatic step(input logic c, input logic [NSRC-1:0] r, input logic l);
        exp_t e;
        @(negedge clk);
        clr      = c;
        bus.req  = r;
        bus.lock = l;
        for (int i = 0; i < NSRC; i++) begin
            data[i] = $urandom;
            bus.src_data[i*WIDTH +: WIDTH] = data[i];
        end
        model_edge(c, r, l, e);
        @(posedge clk);
        q.push_back(e);
    endtask

    function automatic logic [NSRC-1:0] bits(input int a, input int b, input int c);
        logic [NSRC-1:0] v;
        v = '0;
        if (a >= 0) v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        if (c >= 0) v[c] = 1'b1;
        return v;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("bus_valid", 64'(bus.bus_valid), 64'(e.valid));
            check("gnt", 64'(bus.gnt), 64'(e.gnt));
            check("bus_out", 64'(bus.bus_out), 64'(e.data));
            check("timeout", 64'(bus.timeout), 64'(e.tout));
            if (e.valid) check("gnt_idx", 64'(bus.gnt_idx), 64'(e.idx));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NSRC-1:0] r;
        clr          = 1'b1;
        bus.req      = '0;
        bus.lock     = 1'b0;
        bus.src_data = '0;

        // Reset with every source requesting, then release: index 0 wins.
        step(1'b1, '1, 1'b0);
        step(1'b1, '1, 1'b0);
        step(1'b0, '1, 1'b0);
        step(1'b0, '0, 1'b0);

        // Round robin over 3, 7, 20.
        for (int i = 0; i < 7; i++) step(1'b0, bits(3, 7, 20), 1'b0);

        // Lock on 5 with 9 waiting, then release.
        step(1'b1, '0, 1'b0);
        step(1'b0, bits(5, -1, -1), 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, bits(5, 9, -1), 1'b1);
        step(1'b0, bits(5, 9, -1), 1'b0);
        step(1'b0, bits(5, 9, -1), 1'b0);

        // Sole requester drops and returns; back-to-back re-grant first.
        for (int i = 0; i < 3; i++) step(1'b0, bits(12, -1, -1), 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, bits(12, -1, -1), 1'b0);

        // Holder drops with others pending: direct hand-off.
        step(1'b0, bits(12, 23, -1), 1'b1);
        step(1'b0, bits(23, 0, -1), 1'b1);

        // Lock on 2 with 4 pending long enough to hit the hold limit, then reset mid-lock.
        step(1'b1, '0, 1'b0);
        step(1'b0, bits(2, -1, -1), 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, bits(2, 4, -1), 1'b1);
        step(1'b1, bits(2, 4, -1), 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, bits(4, 22, -1), 1'b0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0:       r = '0;
                1:       r = bits(int'($urandom_range(0, NSRC - 1)), -1, -1);
                default: r = NSRC'($urandom & $urandom);
            endcase
            step($urandom_range(0, 40) == 0, r, $urandom_range(0, 2) != 0);
        end

        @(negedge clk);
        @(negedge clk);
        check("drain", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
